// File: rtl/main_memory_ctrl_if.sv
// Cache <-> backing-store bus carrying the Mem* Start/Finish handshake.
//
// Signals:
//   MemReadStart   cache -> mem  read request, held until MemReadFinish is seen
//   MemReadAddr    cache -> mem  byte address of the read
//   MemReadData    mem -> cache  read word, valid while MemReadFinish is high
//   MemReadFinish  mem -> cache  read-complete level
//   MemWriteStart  cache -> mem  write request, held until MemWriteFinish is seen
//   MemWriteAddr   cache -> mem  byte address of the write
//   MemWriteData   cache -> mem  write word
//   MemWriteFinish mem -> cache  write-complete level
//
// Modports: master (cache side), slave (memory controller side).
interface main_memory_ctrl_if;
    logic        MemReadStart;
    logic [31:0] MemReadAddr;
    logic [31:0] MemReadData;
    logic        MemReadFinish;
    logic        MemWriteStart;
    logic [31:0] MemWriteAddr;
    logic [31:0] MemWriteData;
    logic        MemWriteFinish;

    modport master (
        output MemReadStart,
        output MemReadAddr,
        input  MemReadData,
        input  MemReadFinish,
        output MemWriteStart,
        output MemWriteAddr,
        output MemWriteData,
        input  MemWriteFinish
    );

    modport slave (
        input  MemReadStart,
        input  MemReadAddr,
        output MemReadData,
        output MemReadFinish,
        input  MemWriteStart,
        input  MemWriteAddr,
        input  MemWriteData,
        output MemWriteFinish
    );
endinterface

// File: rtl/main_memory_ctrl.sv
// Backing-store controller behind the 4-way data cache. Serves refill reads and dirty-line
// writebacks from a word-addressed RAM with a fixed access latency and a four-phase
// Start/Finish handshake.
//
// Ports:
//   CLK         clock, rising edge
//   Reset       asynchronous active-high reset (RAM contents are not affected)
//   memBus      Mem* handshake bus (slave side)
//   Busy        high whenever the controller is not idle
//   ReadCount   completed reads, saturating at 16'hFFFF
//   WriteCount  completed writes, saturating at 16'hFFFF
//
// Parameters:
//   ADDR_WIDTH  word-address bits; RAM depth is 2**ADDR_WIDTH words of 32 bits
//   LATENCY     edges from accepted Start to Finish, legal range 1..15
//   MARK_STRIDE initial content: word i is 1 when i % MARK_STRIDE == 0, else 0 (must be >= 1)
module main_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned MARK_STRIDE = 256
) (
    input  logic                     CLK,
    input  logic                     Reset,
    main_memory_ctrl_if.slave        memBus,
    output logic                     Busy,
    output logic [15:0]              ReadCount,
    output logic [15:0]              WriteCount
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_DONE = 3'd3;
    localparam logic [2:0] WR_DONE = 3'd4;

    logic [2:0]            state;
    logic [2:0]            stateNext;
    logic [3:0]            latCount;
    logic [ADDR_WIDTH-1:0] latchedAddr;
    logic [31:0]           latchedData;
    logic [31:0]           readData;
    logic [31:0]           ramRead;
    logic [ADDR_WIDTH-1:0] readIdx;
    logic [ADDR_WIDTH-1:0] writeIdx;
    logic                  commitWrite;
    logic                  captureRead;

    // Storage. Words never written since power-up read back the stride pattern, so the
    // initial content needs no preload pass; the mask records which words hold real data.
    logic [31:0]           ram [DEPTH];
    logic [DEPTH-1:0]      writtenMask = '0;

    // Byte-address bits below the word and above the RAM index alias away.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{memBus.MemReadAddr[31:ADDR_WIDTH+2], memBus.MemReadAddr[1:0],
                              memBus.MemWriteAddr[31:ADDR_WIDTH+2], memBus.MemWriteAddr[1:0]};

    assign readIdx  = memBus.MemReadAddr[ADDR_WIDTH+1:2];
    assign writeIdx = memBus.MemWriteAddr[ADDR_WIDTH+1:2];

    function automatic logic [31:0] markWord(input logic [ADDR_WIDTH-1:0] idx);
        return ((32'(idx) % MARK_STRIDE) == 32'd0) ? 32'd1 : 32'd0;
    endfunction

    assign ramRead     = writtenMask[latchedAddr] ? ram[latchedAddr] : markWord(latchedAddr);
    assign commitWrite = (state == WR_WAIT) && (latCount == 4'd0);
    assign captureRead = (state == RD_WAIT) && (latCount == 4'd0);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                // Writeback before refill when both arrive together.
                if (memBus.MemWriteStart) begin
                    stateNext = WR_WAIT;
                end else if (memBus.MemReadStart) begin
                    stateNext = RD_WAIT;
                end
            end
            RD_WAIT: if (latCount == 4'd0) stateNext = RD_DONE;
            WR_WAIT: if (latCount == 4'd0) stateNext = WR_DONE;
            RD_DONE: if (!memBus.MemReadStart) stateNext = IDLE;
            WR_DONE: if (!memBus.MemWriteStart) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            latCount    <= 4'd0;
            latchedAddr <= '0;
            latchedData <= 32'h0;
            readData    <= 32'h0;
            ReadCount   <= 16'h0;
            WriteCount  <= 16'h0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (memBus.MemWriteStart) begin
                        latchedAddr <= writeIdx;
                        latchedData <= memBus.MemWriteData;
                        latCount    <= LAT_INIT;
                    end else if (memBus.MemReadStart) begin
                        latchedAddr <= readIdx;
                        latCount    <= LAT_INIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (latCount != 4'd0) begin
                        latCount <= latCount - 4'd1;
                    end
                    if (captureRead) begin
                        readData <= ramRead;
                    end
                end
                RD_DONE: begin
                    if (!memBus.MemReadStart && ReadCount != 16'hFFFF) begin
                        ReadCount <= ReadCount + 16'd1;
                    end
                end
                WR_DONE: begin
                    if (!memBus.MemWriteStart && WriteCount != 16'hFFFF) begin
                        WriteCount <= WriteCount + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // No reset here: RAM content survives Reset. A reset during WR_WAIT forces IDLE
    // asynchronously, so the pending write never reaches this commit.
    always_ff @(posedge CLK) begin
        if (commitWrite) begin
            ram[latchedAddr]         <= latchedData;
            writtenMask[latchedAddr] <= 1'b1;
        end
    end

    assign memBus.MemReadData     = readData;
    assign memBus.MemReadFinish   = (state == RD_DONE);
    assign memBus.MemWriteFinish  = (state == WR_DONE);
    assign Busy                   = (state != IDLE);

endmodule
